im_loader: RTL and testbench
============================

# im_loader

Program loader for the 4 KB instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written sequentially into the instruction memory write port, starting at word address 0. It holds the single-cycle CPU stalled for the whole load and pulses `done` when the image is complete.

## Interface

Parameters:
- `DEPTH`, 1024: instruction memory depth in words. Must equal 2^10 to match the `[11:2]` address.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle request to begin a load. Only honoured in IDLE.
- `len`, input, 11: number of words to load. Sampled on an accepted `start`; legal range 1..1024.
- `in_data`, input, 8: stream byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: loader accepts a byte this cycle. A transfer happens when `in_valid & in_ready`.
- `im_we`, output, 1: instruction memory write enable, one cycle per word.
- `im_addr`, output, [11:2]: word address of the write.
- `im_din`, output, 32: word being written.
- `busy`, output, 1: a load is in progress.
- `cpu_hold`, output, 1: stall/reset request to the CPU during a load.
- `done`, output, 1: one-cycle pulse when the load completes.
- `err`, output, 1: checksum mismatch flag. Always 0 unless `IM_LOADER_CSUM_EN` is defined.

## Operation

States:
- IDLE, LOAD, CSUM (only with `IM_LOADER_CSUM_EN`), DONE.

Transitions:
- **IDLE → LOAD** on `start` when 1 ≤ `len` ≤ 1024. On entry: `len` is latched, `word_cnt` = 0, `byte_idx` = 0, `err` is cleared.
- **Illegal `start`:** when `len` is 0 or greater than 1024, `start` is ignored and the state stays IDLE.
- **LOAD:**
  - `in_ready` = 1.
  - Each transfer places `in_data` in byte lane `byte_idx`, so the first byte lands in bits [7:0] and the fourth in [31:24]. `byte_idx` then increments modulo 4.
  - When the 4th byte is accepted, the assembled word is registered onto `im_din`, `word_cnt` is registered onto `im_addr`, and `im_we` is asserted in the next cycle. `word_cnt` then increments.
  - When the accepted byte completes word number `len`-1, the next state is DONE, or CSUM if the macro is defined.
- **CSUM:** `in_ready` = 1. The next accepted byte is the checksum byte, then the state moves to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then the state returns to IDLE.

Rules:
- `start` asserted outside IDLE is ignored.
- `busy` = 1 in LOAD and CSUM. `cpu_hold` = 1 in LOAD, CSUM and DONE.
- Addresses never wrap. With `len` = 1024 the last write goes to address 1023, and address 0 is never rewritten.
- `im_din` and `im_addr` hold their last value when `im_we` = 0.

## Timing

- Reset values: state IDLE; `in_ready`, `im_we`, `busy`, `cpu_hold`, `done` and `err` are 0; `im_addr` = 0; `im_din` = 0. Internal counters and the partial word are 0.
- Reset mid-load aborts immediately. A partially assembled word is discarded, and no `im_we` follows the deassertion of reset.
- `in_ready` is a pure decode of the registered state, with no combinational path from `in_valid`. The loader can sustain one byte per cycle, so one word takes 4 cycles.
- Write latency: `im_we` is high in the cycle after the 4th byte of a word is accepted.
- Without the macro, `done` coincides with the `im_we` of the last word.
- With the macro, the last `im_we` falls in the first CSUM cycle. `done` and the final `err` value appear in the cycle after the checksum byte is accepted.
- Gaps in `in_valid` simply stall; there is no timeout.
- `start` in the DONE cycle is ignored. It is accepted from IDLE, i.e. one cycle later at the earliest.

## Configuration

`IM_LOADER_CSUM_EN`:
- **Defined:**
  - An 8-bit running sum of all payload bytes is kept, modulo 256.
  - After the last word, one extra checksum byte is consumed in CSUM.
  - `err` is set in the DONE cycle when (sum + checksum byte) mod 256 ≠ 0.
  - `err` stays set until the next accepted `start` or reset.
- **Undefined:** the CSUM state and the sum register are absent. `err` is tied to 0 and the stream carries payload only.

## Test plan

- **Basic load:** `len` = 2, bytes 78 56 34 12 EF BE AD DE at one byte per cycle → writes addr 0 = 0x12345678 and addr 1 = 0xDEADBEEF. `done` pulses once, and `busy`/`cpu_hold` drop afterwards.
- **Backpressure and gaps:** random `in_valid` gaps during a 3-word load → identical write data and addresses. Exactly 3 `im_we` pulses occur, and nothing is written while `in_valid` = 0.
- **Illegal length and start-while-busy:** `start` with `len` = 0 and with `len` = 1025 → stays IDLE with `in_ready` = 0. `start` pulsed mid-load → no restart and `word_cnt` is unaffected.
- **Reset mid-word:** assert `rst_n` low after 2 bytes of word 1 → all outputs return to reset values and no `im_we` follows. A new load then starts cleanly at addr 0.
- **Full depth:** `len` = 1024 with incrementing words → the last write goes to addr 1023, there is no write to addr 0 after the first, and `done` pulses once.
- **Checksum (macro defined):** bytes 01 02 03 04 followed by checksum F6 → `err` = 0. The same payload followed by F7 → `err` = 1 at `done`, held until the next `start`.

Source files
------------

// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them from address 0 while holding the CPU. Optional checksum: IM_LOADER_CSUM_EN.
module im_loader #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] len,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        im_we,
    output logic [11:2] im_addr,
    output logic [31:0] im_din,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    // state | meaning
    // IDLE  | waiting for a legal start
    // LOAD  | accepting payload bytes, one write per four bytes
    // CSUM  | accepting the trailing checksum byte (IM_LOADER_CSUM_EN only)
    // DONE  | one-cycle completion pulse, CPU still held
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
`ifdef IM_LOADER_CSUM_EN
        S_CSUM = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] len_q;
    logic [9:0]  word_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;

    logic start_ok, xfer, last_byte, last_word;

    assign start_ok  = start && (len != 11'd0) && (len <= 11'(DEPTH));
    assign xfer      = in_valid && in_ready;
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = ({1'b0, word_cnt} == (len_q - 11'd1));

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (xfer && last_byte && last_word) begin
`ifdef IM_LOADER_CSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IM_LOADER_CSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (xfer) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                cpu_hold = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= 11'd0;
            word_cnt <= 10'd0;
            byte_idx <= 2'd0;
            word_buf <= 24'd0;
            im_we    <= 1'b0;
            im_addr  <= 10'd0;
            im_din   <= 32'd0;
        end else begin
            state_q <= state_d;
            im_we   <= 1'b0;
            if (state_q == S_IDLE && start_ok) begin
                len_q    <= len;
                word_cnt <= 10'd0;
                byte_idx <= 2'd0;
            end
            if (state_q == S_LOAD && xfer) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word_buf[7:0]   <= in_data;
                    2'd1: word_buf[15:8]  <= in_data;
                    2'd2: word_buf[23:16] <= in_data;
                    default: begin
                        im_din   <= {in_data, word_buf};
                        im_addr  <= word_cnt;
                        im_we    <= 1'b1;
                        word_cnt <= word_cnt + 10'd1;
                    end
                endcase
            end
        end
    end

`ifdef IM_LOADER_CSUM_EN
    logic [7:0] sum_q;

    // err is registered on the checksum byte so it is valid in the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'd0;
            err   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start_ok) begin
                sum_q <= 8'd0;
                err   <= 1'b0;
            end
            if (state_q == S_LOAD && xfer) sum_q <= sum_q + in_data;
            if (state_q == S_CSUM && xfer) err <= ((sum_q + in_data) != 8'd0);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: stimulus queues expected writes, a negedge monitor checks them.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] len = 11'd0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, im_we, busy, cpu_hold, done, err;
    logic [11:2] im_addr;
    logic [31:0] im_din;

    im_loader #(.DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_din(im_din),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic        err_at_done = 1'b0;
    logic [41:0] exp_q[$];
    logic [41:0] exp_e;
    logic [31:0] img[1024];
    logic [7:0]  csum = 8'd0;

    always @(negedge clk) begin
        if (im_we) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr=%0d data=%h, required no write", im_addr, im_din);
            end else begin
                exp_e = exp_q.pop_front();
                if ({im_addr, im_din} !== exp_e) begin
                    fails++;
                    $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                             im_addr, im_din, exp_e[41:32], exp_e[31:0]);
                end
            end
        end
        if (done) begin
            done_cnt++;
            err_at_done = err;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   n;
        in_valid = 1'b0;
        tick(gap);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic start_load(input int n);
        start = 1'b1;
        len   = 11'(n);
        tick(1);
        start = 1'b0;
        csum  = 8'd0;
    endtask

    task automatic send_word(input int w, input bit gaps);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) exp_q.push_back({w[9:0], img[w]});
            csum = csum + img[w][8*b +: 8];
            send_byte(img[w][8*b +: 8], gaps ? ((w + b) % 3) : 0);
        end
    endtask

    task automatic finish_load(input int d0, input logic [7:0] cadj);
`ifdef IM_LOADER_CSUM_EN
        send_byte(8'(8'd0 - csum + cadj), 0);
`else
        if (cadj != 8'd0) $display("[TB] checksum adjust ignored without checksum build");
`endif
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick(1);
        tick(2);
        check("done_pulses", done_cnt, d0 + 1);
        check("busy_after", busy, 0);
        check("hold_after", cpu_hold, 0);
        check("pending_writes", exp_q.size(), 0);
    endtask

    task automatic do_load(input int n, input bit gaps, input logic [7:0] cadj);
        int d0;
        d0 = done_cnt;
        start_load(n);
        for (int w = 0; w < n; w++) send_word(w, gaps);
        finish_load(d0, cadj);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_im_we"}, im_we, 0);
        check({tag, "_im_addr"}, im_addr, 0);
        check({tag, "_im_din"}, im_din, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int d0;
        #2;
        check_reset_outputs("reset");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // basic two-word load
        img[0] = 32'h12345678;
        img[1] = 32'hDEADBEEF;
        do_load(2, 1'b0, 8'd0);

        // in_valid gaps
        img[0] = 32'hA1B2C3D4;
        img[1] = 32'h00FF00FF;
        img[2] = 32'h80000001;
        do_load(3, 1'b1, 8'd0);

        // illegal lengths are ignored
        start_load(0);
        check("len0_ready", in_ready, 0);
        check("len0_busy", busy, 0);
        start_load(1025);
        check("len1025_ready", in_ready, 0);
        check("len1025_busy", busy, 0);
        tick(3);

        // start pulsed mid-load must not restart
        img[0] = 32'h11111111;
        img[1] = 32'h22222222;
        img[2] = 32'h33333333;
        d0 = done_cnt;
        start_load(3);
        send_word(0, 1'b0);
        start = 1'b1;
        len   = 11'd5;
        tick(1);
        start = 1'b0;
        check("midstart_busy", busy, 1);
        send_word(1, 1'b0);
        send_word(2, 1'b0);
        finish_load(d0, 8'd0);

        // reset in the middle of word 1
        img[0] = 32'hCAFEF00D;
        img[1] = 32'h55AA55AA;
        start_load(2);
        send_word(0, 1'b0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick(3);
        rst_n = 1'b1;
        tick(6);
        check("midreset_no_writes", exp_q.size(), 0);
        img[0] = 32'h0BADC0DE;
        do_load(1, 1'b0, 8'd0);

        // full depth
        for (int i = 0; i < 1024; i++) img[i] = (32'(i) * 32'h00010001) ^ 32'hA5000000;
        do_load(1024, 1'b0, 8'd0);

`ifdef IM_LOADER_CSUM_EN
        img[0] = 32'h04030201;
        do_load(1, 1'b0, 8'd0);
        check("csum_good_err", err_at_done, 0);
        do_load(1, 1'b0, 8'd1);
        check("csum_bad_err", err_at_done, 1);
        tick(3);
        check("csum_err_held", err, 1);
        d0 = done_cnt;
        start_load(1);
        check("csum_err_cleared", err, 0);
        send_word(0, 1'b0);
        finish_load(d0, 8'd0);
`else
        check("err_tied", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
